// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: shared size encodings, FSM state type and alignment helper
// for the MIPS load/store unit.
package mips_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   // Half needs an even address, word needs a 4-byte aligned address.
   // The unused size code 2'b11 is treated as a word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         default: mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// mips_lsu_if: pipeline request/response, memory port and reservation
// invalidate signals of the load/store unit, bundled for port connection.
interface mips_lsu_if #(parameter int ADDR_W = 32);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic              req_atomic;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;

   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic [4:0]        rsp_rd;
   logic              rsp_wb;
   logic              rsp_misaligned;

   logic              mem_read_en;
   logic [3:0]        mem_write_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;
   logic              mem_ack;

   logic              stall;
   logic              resv_clear;

   // Pipeline / memory side (drives requests and memory replies).
   modport master (
      output req_valid, req_we, req_size, req_signed, req_atomic, req_addr, req_wdata, req_rd,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_rd, rsp_wb, rsp_misaligned,
      input  mem_read_en, mem_write_en, mem_addr, mem_write_data,
      output mem_read_data, mem_ack,
      input  stall,
      output resv_clear
   );

   // Load/store unit side.
   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_atomic, req_addr, req_wdata, req_rd,
      output req_ready,
      output rsp_valid, rsp_data, rsp_rd, rsp_wb, rsp_misaligned,
      output mem_read_en, mem_write_en, mem_addr, mem_write_data,
      input  mem_read_data, mem_ack,
      output stall,
      input  resv_clear
   );

endinterface

// File: rtl/mips_lsu_lane.sv
// mips_lsu_lane: big-endian byte-lane steering. Builds write enables and
// replicated store data, and extracts/extends the addressed load lane.
module mips_lsu_lane
   import mips_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] load_raw,
   output logic [3:0]  byte_en,
   output logic [31:0] store_lanes,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Lane selection: offset 0 is the most significant byte/half.
   always_comb begin
      byte_en     = 4'b0000;
      store_lanes = 32'h0000_0000;
      load_data   = 32'h0000_0000;
      lane_b      = 8'h00;
      lane_h      = 16'h0000;
      case (size)
         SZ_BYTE: begin
            byte_en     = 4'b1000 >> offset;
            store_lanes = {4{store_data[7:0]}};
            case (offset)
               2'b00:   lane_b = load_raw[31:24];
               2'b01:   lane_b = load_raw[23:16];
               2'b10:   lane_b = load_raw[15:8];
               default: lane_b = load_raw[7:0];
            endcase
            load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
         end
         SZ_HALF: begin
            byte_en     = offset[1] ? 4'b0011 : 4'b1100;
            store_lanes = {2{store_data[15:0]}};
            lane_h      = offset[1] ? load_raw[15:0] : load_raw[31:16];
            load_data   = {{16{sign_ext & lane_h[15]}}, lane_h};
         end
         default: begin
            byte_en     = 4'b1111;
            store_lanes = store_data;
            load_data   = load_raw;
         end
      endcase
   end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: single-outstanding load/store unit with LL/SC support.
// Optional feature: define MIPS_LSU_LLSC_EN to build the LL/SC reservation;
// without it LL is a plain load and SC always writes and returns 1.
module mips_lsu
   import mips_lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int RESV_LOG2 = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      en,
   mips_lsu_if.slave bus
);

   localparam int TAG_W = ADDR_W - RESV_LOG2;

   state_t            state;
   state_t            next_state;

   logic              r_we;
   logic [1:0]        r_size;
   logic              r_signed;
   logic              r_atomic;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [4:0]        r_rd;
   logic              r_mis;
   logic              r_sc_ok;
   logic [31:0]       r_rdata;

   logic              accept;
   logic              req_mis;
   logic              resv_hit;
   logic              sc_fail;
   logic              mem_done;

   logic [3:0]        lane_be;
   logic [31:0]       lane_wd;
   logic [31:0]       lane_ld;

   assign accept   = (state == IDLE) && bus.req_valid && en;
   assign req_mis  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
   assign mem_done = (state == WAIT) && bus.mem_ack && en;

`ifdef MIPS_LSU_LLSC_EN
   logic             resv_valid;
   logic [TAG_W-1:0] resv_tag;

   assign resv_hit = resv_valid && (resv_tag == bus.req_addr[ADDR_W-1:RESV_LOG2]);

   // Reservation: external clear has priority, then any store that really
   // writes the reserved granule (plain or successful SC), then LL completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resv_valid <= 1'b0;
         resv_tag   <= {TAG_W{1'b0}};
      end else if (en) begin
         if (bus.resv_clear) begin
            resv_valid <= 1'b0;
         end else if (accept && bus.req_we && !req_mis && resv_hit) begin
            resv_valid <= 1'b0;
         end else if (mem_done && r_atomic && !r_we) begin
            resv_valid <= 1'b1;
            resv_tag   <= r_addr[ADDR_W-1:RESV_LOG2];
         end
      end
   end
`else
   logic unused_resv;
   assign unused_resv = bus.resv_clear;
   assign resv_hit    = 1'b1;
`endif

   assign sc_fail = bus.req_we && bus.req_atomic && !resv_hit;

   mips_lsu_lane u_lane (
      .size        (r_size),
      .sign_ext    (r_signed),
      .offset      (r_addr[1:0]),
      .store_data  (r_wdata),
      .load_raw    (r_rdata),
      .byte_en     (lane_be),
      .store_lanes (lane_wd),
      .load_data   (lane_ld)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: requests without a memory access skip straight to RESP.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (req_mis || sc_fail) ? RESP : WAIT;
            end else begin
               next_state = IDLE;
            end
         end
         WAIT: begin
            if (mem_done) begin
               next_state = RESP;
            end else begin
               next_state = WAIT;
            end
         end
         RESP: begin
            if (en) begin
               next_state = IDLE;
            end else begin
               next_state = RESP;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Request latch at acceptance and read-data capture on memory completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_atomic <= 1'b0;
         r_addr   <= {ADDR_W{1'b0}};
         r_wdata  <= 32'h0000_0000;
         r_rd     <= 5'd0;
         r_mis    <= 1'b0;
         r_sc_ok  <= 1'b0;
         r_rdata  <= 32'h0000_0000;
      end else if (accept) begin
         r_we     <= bus.req_we;
         r_size   <= bus.req_size;
         r_signed <= bus.req_signed;
         r_atomic <= bus.req_atomic;
         r_addr   <= bus.req_addr;
         r_wdata  <= bus.req_wdata;
         r_rd     <= bus.req_rd;
         r_mis    <= req_mis;
         r_sc_ok  <= resv_hit;
      end else if (mem_done) begin
         r_rdata  <= bus.mem_read_data;
      end
   end

   // Outputs decoded from the state and latched request only.
   always_comb begin
      bus.req_ready      = (state == IDLE);
      bus.stall          = (state != IDLE);
      bus.mem_read_en    = 1'b0;
      bus.mem_write_en   = 4'b0000;
      bus.mem_addr       = {ADDR_W{1'b0}};
      bus.mem_write_data = 32'h0000_0000;
      bus.rsp_valid      = 1'b0;
      bus.rsp_data       = 32'h0000_0000;
      bus.rsp_rd         = 5'd0;
      bus.rsp_wb         = 1'b0;
      bus.rsp_misaligned = 1'b0;
      case (state)
         WAIT: begin
            bus.mem_addr = r_addr;
            if (r_we) begin
               bus.mem_write_en   = lane_be;
               bus.mem_write_data = lane_wd;
            end else begin
               bus.mem_read_en    = 1'b1;
            end
         end
         RESP: begin
            bus.rsp_valid      = 1'b1;
            bus.rsp_rd         = r_rd;
            bus.rsp_misaligned = r_mis;
            if (r_mis) begin
               bus.rsp_data = 32'h0000_0000;
               bus.rsp_wb   = 1'b0;
            end else if (!r_we) begin
               bus.rsp_data = lane_ld;
               bus.rsp_wb   = 1'b1;
            end else if (r_atomic) begin
               bus.rsp_data = {31'd0, r_sc_ok};
               bus.rsp_wb   = 1'b1;
            end else begin
               bus.rsp_data = 32'h0000_0000;
               bus.rsp_wb   = 1'b0;
            end
         end
         default: begin
            bus.rsp_valid = 1'b0;
         end
      endcase
   end

endmodule
